serial_job_sequencer: RTL
=========================

Name: serial_job_sequencer

Overview:
Sequences the serial-mode MAC engine (top_serial_mode) over a batch of feature vectors. Per job it:
- drives the engine's enable and feature base address;
- waits for the engine's done;
- captures the 8-bit result and hands it downstream over a valid/ready port.

It sits between the host/control FSM and the engine, replacing manual en/feature_baseaddr toggling. A watchdog flags a hung engine.

Parameters:
ADDR_W, 8, width of feature base address
DATA_W, 8, width of engine result
CNT_W, 4, width of job count/index (max 15 jobs)
TIMEOUT, 1024, max cycles in WAIT before error (≥2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  launch batch; sampled only in IDLE
abort_i  in  1  synchronous abort, highest priority after rst
base_addr_i  in  ADDR_W  first feature base address, latched on start
stride_i  in  ADDR_W  address increment per job, latched on start
num_jobs_i  in  CNT_W  number of jobs, latched on start
eng_en_o  out  1  engine enable (to en)
eng_baseaddr_o  out  ADDR_W  engine feature base address
eng_done_i  in  1  engine done level (from is_done_o)
eng_out_i  in  DATA_W  engine result (from out)
res_valid_o  out  1  result valid
res_data_o  out  DATA_W  captured result
res_idx_o  out  CNT_W  job index of result
res_ready_i  in  1  downstream accepts result
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse when batch completes
err_o  out  1  watchdog error, held in ERROR

Behaviour:
- Reset: all outputs 0, state IDLE, idx 0, timer 0, latched config 0.
- States:
  - IDLE:
    - start_i=1, num_jobs_i≠0: latch config; eng_baseaddr_o←base_addr_i; eng_en_o←1; idx←0; timer←0; →WAIT. eng_en_o is therefore high 1 cycle after start is sampled.
    - start_i=1, num_jobs_i=0: done_o pulses next cycle; stay IDLE; engine untouched.
  - WAIT:
    - timer increments each cycle.
    - eng_done_i=1: res_data_o←eng_out_i; res_idx_o←idx; res_valid_o←1; eng_en_o←0; →DRAIN. Done has priority over timeout in the same cycle.
    - Else if timer=TIMEOUT-1: eng_en_o←0; err_o←1; →ERROR.
  - DRAIN:
    - eng_en_o low (≥1 cycle guaranteed; engine must drop done within 1 cycle of en low).
    - On res_valid_o&res_ready_i, res_valid_o←0, then:
      - idx=num_jobs-1: done_o pulse; →IDLE.
      - Otherwise: idx←idx+1; eng_baseaddr_o←eng_baseaddr_o+stride (mod 2^ADDR_W, wraps silently); eng_en_o←1; timer←0; →WAIT.
    - res_data_o/res_idx_o stable while res_valid_o=1 and ready low (standard valid/ready, no retraction).
  - ERROR: err_o=1; eng_en_o=0; start_i ignored; exit only via abort_i or rst.
- abort_i=1 in any state: next cycle eng_en_o=0, res_valid_o=0, err_o=0, done_o=0, state IDLE. Abort wins over start, done and timeout in the same cycle; a result pending in DRAIN is dropped.
- start_i in a non-IDLE state is ignored; config inputs are ignored except at accepted start.
- eng_baseaddr_o holds its last value in IDLE/ERROR.
- rst mid-batch: immediate return to reset values; no done_o.
- Throughput: min 2 cycles per job overhead beyond engine latency (DRAIN + capture), with res_ready_i tied high.

Decomposition:
- Shared package serial_seq_pkg:
  - state encoding localparams (IDLE=0, WAIT=1, DRAIN=2, ERROR=3);
  - default ADDR_W/DATA_W/CNT_W;
  - TIMEOUT default and timer width via $clog2(TIMEOUT).
- One sub-module: serial_seq_watchdog (clear, enable, expire-at-TIMEOUT-1 counter), instantiated once.
- Everything else stays in the FSM.

Test Plan:
- base=0x09, stride=0x01, num=3, engine model done 5 cycles after en, ready=1 → eng_baseaddr_o 0x09,0x0A,0x0B; res_idx_o 0,1,2 with matching eng_out_i values; done_o single pulse; busy_o low after.
- base=0xFE, stride=0x03, num=2 → second address 0x01 (wrap).
- num=1, res_ready_i held low 10 cycles → res_valid_o and res_data_o held stable 10 cycles; eng_en_o stays 0; done_o one cycle after ready rises.
- TIMEOUT=16, engine never asserts done → err_o=1 exactly 16 cycles after eng_en_o rises, eng_en_o=0; start ignored; abort_i clears err_o, busy_o next cycle.
- abort_i in same cycle as eng_done_i in WAIT → no res_valid_o; IDLE next cycle. rst asserted mid-DRAIN → all outputs 0 immediately.
- start with num=0 → done_o pulse next cycle, eng_en_o never rises; start while busy → ignored, batch unchanged.

Source files
------------

// File: rtl/serial_seq_pkg.sv
// Shared types and defaults for the serial job sequencer: state encoding,
// default widths and the watchdog timeout.
package serial_seq_pkg;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  function automatic int timer_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction
endpackage

// File: rtl/serial_seq_watchdog.sv
// Cycle counter guarding the WAIT state; o_expired is high when the count
// reaches TIMEOUT-1, i.e. on the last cycle the engine is allowed to answer.
module serial_seq_watchdog
  import serial_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int TW = timer_w(TIMEOUT);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == TW'(TIMEOUT - 1));
endmodule

// File: rtl/serial_job_sequencer.sv
// Runs the serial-mode MAC engine over a batch of feature vectors, one job
// per base address, and forwards each result over a valid/ready port.
module serial_job_sequencer
  import serial_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  num_jobs_i,
  output logic              eng_en_o,
  output logic [ADDR_W-1:0] eng_baseaddr_o,
  input  logic              eng_done_i,
  input  logic [DATA_W-1:0] eng_out_i,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic [CNT_W-1:0]  res_idx_o,
  input  logic              res_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  state_e            r_state, w_state_n;
  logic              r_en, w_en_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [ADDR_W-1:0] r_stride, w_stride_n;
  logic [CNT_W-1:0]  r_num, w_num_n;
  logic [CNT_W-1:0]  r_idx, w_idx_n;
  logic              r_valid, w_valid_n;
  logic [DATA_W-1:0] r_data, w_data_n;
  logic [CNT_W-1:0]  r_res_idx, w_res_idx_n;
  logic              r_done, w_done_n;
  logic              r_err, w_err_n;
  logic              w_wd_clr, w_wd_en, w_expired;

  serial_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_en      <= 1'b0;
      r_addr    <= '0;
      r_stride  <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_res_idx <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_en      <= w_en_n;
      r_addr    <= w_addr_n;
      r_stride  <= w_stride_n;
      r_num     <= w_num_n;
      r_idx     <= w_idx_n;
      r_valid   <= w_valid_n;
      r_data    <= w_data_n;
      r_res_idx <= w_res_idx_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_en_n      = r_en;
    w_addr_n    = r_addr;
    w_stride_n  = r_stride;
    w_num_n     = r_num;
    w_idx_n     = r_idx;
    w_valid_n   = r_valid;
    w_data_n    = r_data;
    w_res_idx_n = r_res_idx;
    w_done_n    = 1'b0;
    w_err_n     = r_err;
    w_wd_clr    = 1'b0;
    w_wd_en     = 1'b0;
    if (abort_i) begin
      // Abort drops any pending result; the address register keeps its value.
      w_state_n = S_IDLE;
      w_en_n    = 1'b0;
      w_valid_n = 1'b0;
      w_err_n   = 1'b0;
      w_wd_clr  = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (num_jobs_i != '0) begin
              w_stride_n = stride_i;
              w_num_n    = num_jobs_i;
              w_addr_n   = base_addr_i;
              w_idx_n    = '0;
              w_en_n     = 1'b1;
              w_wd_clr   = 1'b1;
              w_state_n  = S_WAIT;
            end else begin
              w_done_n = 1'b1;
            end
          end
        end
        S_WAIT: begin
          w_wd_en = 1'b1;
          if (eng_done_i) begin
            w_data_n    = eng_out_i;
            w_res_idx_n = r_idx;
            w_valid_n   = 1'b1;
            w_en_n      = 1'b0;
            w_state_n   = S_DRAIN;
          end else if (w_expired) begin
            w_en_n    = 1'b0;
            w_err_n   = 1'b1;
            w_state_n = S_ERROR;
          end
        end
        S_DRAIN: begin
          if (r_valid && res_ready_i) begin
            w_valid_n = 1'b0;
            if (r_idx == r_num - CNT_W'(1)) begin
              w_done_n  = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_idx_n   = r_idx + CNT_W'(1);
              w_addr_n  = r_addr + r_stride;
              w_en_n    = 1'b1;
              w_wd_clr  = 1'b1;
              w_state_n = S_WAIT;
            end
          end
        end
        S_ERROR: ;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  assign eng_en_o       = r_en;
  assign eng_baseaddr_o = r_addr;
  assign res_valid_o    = r_valid;
  assign res_data_o     = r_data;
  assign res_idx_o      = r_res_idx;
  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = r_done;
  assign err_o          = r_err;
endmodule
